record_mode: RTL and testbench
==============================

# record_mode

Captures a melody played live on the note keys into an internal track memory, quantising each note and rest to a length code. It is the writer for the song-track interface that playback reads: entries are octave/note/length triples addressed by a counter, with a track length marking the end. It sits beside play mode under the top-level mode selector and exposes a registered read port, so a recorded track can be replayed with the same cnt/track sequencing used for ROM songs.

## Interface
- DEPTH_BITS, 6, address width; track holds 2^DEPTH_BITS entries
- OCTAVE_BITS, 3, octave field width
- NOTE_BITS, 4, note field width; 0 = rest, 1..7 = do..ti
- LENGTH_BITS, 3, length code width
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  record-mode enable; rising level starts a take, falling level ends it
- beat_tick  in  1  one-cycle pulse per 1/16-note time unit
- oct_up, oct_down  in  1  one-cycle octave step pulses
- note_key  in  3  synchronous debounced key code; 0..6 = note 1..7, 7 = no key
- rd_addr  in  DEPTH_BITS  playback read address
- rd_octave, rd_note, rd_length  out  OCTAVE/NOTE/LENGTH_BITS  registered read data
- track  out  DEPTH_BITS+1  number of valid entries in the last completed take
- recording  out  1  high in ARMED/HOLD/GAP
- full  out  1  take stopped because memory filled
- octave  out  OCTAVE_BITS  current recording octave

## Operation
- States: IDLE, ARMED, HOLD, GAP, CLOSE, DONE.
- IDLE: waits for en=1. When en=1: cnt<=0, octave<=4, full<=0, key_q<=7, go to ARMED. track keeps the previous take's value.
- ARMED: no leading rest. On note_key!=7: latch note=note_key+1, lat_oct=octave, dur<=0, key_q<=note_key, go to HOLD.
- HOLD:
  - beat_tick increments dur, saturating at 31.
  - On note_key!=key_q: write {lat_oct, note, q(dur)} at cnt and increment cnt.
  - If the new key !=7: latch it and stay in HOLD with dur<=0. Otherwise go to GAP with dur<=0.
- GAP:
  - beat_tick increments dur, saturating.
  - On note_key!=7: if dur>=1, write a rest {lat_oct, 0, q(dur)} and increment cnt. If dur=0, write nothing.
  - In both cases latch the new note and go to HOLD.
- Quantiser q(dur): 0–1→0 (1/16), 2–3→1 (1/8), 4–7→2 (1/4), 8–15→3 (1/2), >=16→4 (whole). Codes 5–7 are never written.
- en=0 in ARMED/HOLD/GAP: go to CLOSE.
  - CLOSE writes the pending note only if it came from HOLD. A pending rest is discarded.
  - Then track<=cnt (after that write) and go to DONE.
- Full: a write that makes cnt=2^DEPTH_BITS sets full=1 and track<=2^DEPTH_BITS, and goes to DONE. No further writes occur; keys are ignored.
- DONE: waits for en=0, then goes to IDLE. A new take needs en to go low then high again.
- Octave: oct_up/oct_down change octave by ±1, clamped to 1..7, only while recording. If both are high in one cycle, octave does not change. A note uses the octave latched at its key press.
- Memory: 2^DEPTH_BITS × (OCTAVE+NOTE+LENGTH) bits, one write port and one synchronous read port. Contents are not cleared by reset.

## Timing
- Reset values:
  - state=IDLE, cnt=0, track=0, octave=4, full=0, key_q=7, dur=0
  - rd_* = 0
  - recording=0
- A write commits on the same rising edge where note_key!=key_q is sampled. cnt and track are registered.
- Read latency: rd_* reflect mem[rd_addr] one clock after rd_addr is sampled.
- Reading and writing the same address in the same cycle returns the old data.
- Key change and beat_tick in the same cycle: the closing entry uses dur before increment. The new dur starts at 0.
- en falling to track valid takes 2 cycles (CLOSE, then track update).
- Asynchronous reset mid-take:
  - All state returns to IDLE immediately; the partial take is lost (track=0).
  - Memory contents remain but are not valid.

## Test plan
- Reset, en=1, key 0 held 4 ticks, release, en=0 → one entry {4,1,2}; track=1; full=0.
- Key 2 for 8 ticks, no key for 3 ticks, key 4 for 1 tick, en=0 → entries {4,3,3}, {4,0,1}, {4,5,0}; track=3.
- Key 1 directly to key 5 in one cycle, with beat_tick in that same cycle → entry {oct,2,q(dur)} uses the pre-increment dur; note 6 starts with dur=0.
- oct_up ×5 → octave=7 (clamped); press key 6 for 20 ticks → entry {7,7,4}; simultaneous up+down pulse → octave unchanged.
- 64 one-tick notes played back to back → full=1 after the 64th write; track=64; a 65th key press writes nothing.
- rst_n pulsed low while in HOLD → recording=0, track=0, octave=4 immediately; rd_addr=0 returns the stored entry after a 1-cycle read latency.

Source files
------------

// File: rtl/record_mode.sv
`default_nettype none
// ============================================================================
// Module   : record_mode
// Captures live note-key input as quantised {octave, note, length} entries.
// Revision : 1.0
// ============================================================================
module record_mode #(
    parameter int DEPTH_BITS  = 6,
    parameter int OCTAVE_BITS = 3,
    parameter int NOTE_BITS   = 4,
    parameter int LENGTH_BITS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   beat_tick,
    input  logic                   oct_up,
    input  logic                   oct_down,
    input  logic [2:0]             note_key,
    input  logic [DEPTH_BITS-1:0]  rd_addr,
    output logic [OCTAVE_BITS-1:0] rd_octave,
    output logic [NOTE_BITS-1:0]   rd_note,
    output logic [LENGTH_BITS-1:0] rd_length,
    output logic [DEPTH_BITS:0]    track,
    output logic                   recording,
    output logic                   full,
    output logic [OCTAVE_BITS-1:0] octave
);

    localparam int                     c_ENTRY_W   = OCTAVE_BITS + NOTE_BITS + LENGTH_BITS;
    localparam int                     c_DEPTH     = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]    c_FULL_CNT  = (DEPTH_BITS+1)'(c_DEPTH);
    localparam logic [OCTAVE_BITS-1:0] c_OCT_RESET = OCTAVE_BITS'(4);
    localparam logic [OCTAVE_BITS-1:0] c_OCT_MIN   = OCTAVE_BITS'(1);
    localparam logic [OCTAVE_BITS-1:0] c_OCT_MAX   = OCTAVE_BITS'(7);
    localparam logic [2:0]             c_NO_KEY    = 3'd7;
    localparam logic [4:0]             c_DUR_MAX   = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_HOLD  = 3'd2,
        S_GAP   = 3'd3,
        S_CLOSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  r_state,     w_state_nxt;
    logic [DEPTH_BITS:0]     r_cnt,       w_cnt_nxt;
    logic [DEPTH_BITS:0]     r_track,     w_track_nxt;
    logic [OCTAVE_BITS-1:0]  r_octave,    w_octave_nxt;
    logic                    r_full,      w_full_nxt;
    logic [2:0]              r_key_q,     w_key_q_nxt;
    logic [4:0]              r_dur,       w_dur_nxt;
    logic [NOTE_BITS-1:0]    r_note,      w_note_nxt;
    logic [OCTAVE_BITS-1:0]  r_lat_oct,   w_lat_oct_nxt;
    logic                    r_from_hold, w_from_hold_nxt;

    logic                    w_wr_en;
    logic [c_ENTRY_W-1:0]    w_wr_data;
    logic [DEPTH_BITS:0]     w_cnt_inc;
    logic                    w_wr_fills;
    logic [4:0]              w_dur_inc;
    logic                    w_recording;

    logic [c_ENTRY_W-1:0]    r_mem [c_DEPTH];
    logic [c_ENTRY_W-1:0]    r_rd_data;

    // Length codes: 1/16, 1/8, 1/4, 1/2, whole.
    function automatic logic [LENGTH_BITS-1:0] f_quant(input logic [4:0] d);
        if (d >= 5'd16)     return LENGTH_BITS'(3'd4);
        else if (d >= 5'd8) return LENGTH_BITS'(3'd3);
        else if (d >= 5'd4) return LENGTH_BITS'(3'd2);
        else if (d >= 5'd2) return LENGTH_BITS'(3'd1);
        else                return LENGTH_BITS'(3'd0);
    endfunction

    assign w_recording = (r_state == S_ARMED) || (r_state == S_HOLD) || (r_state == S_GAP);
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_wr_fills  = (w_cnt_inc == c_FULL_CNT);
    assign w_dur_inc   = (r_dur == c_DUR_MAX) ? r_dur : r_dur + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_track     <= '0;
            r_octave    <= c_OCT_RESET;
            r_full      <= 1'b0;
            r_key_q     <= c_NO_KEY;
            r_dur       <= '0;
            r_note      <= '0;
            r_lat_oct   <= '0;
            r_from_hold <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_track     <= w_track_nxt;
            r_octave    <= w_octave_nxt;
            r_full      <= w_full_nxt;
            r_key_q     <= w_key_q_nxt;
            r_dur       <= w_dur_nxt;
            r_note      <= w_note_nxt;
            r_lat_oct   <= w_lat_oct_nxt;
            r_from_hold <= w_from_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_track_nxt     = r_track;
        w_octave_nxt    = r_octave;
        w_full_nxt      = r_full;
        w_key_q_nxt     = r_key_q;
        w_dur_nxt       = r_dur;
        w_note_nxt      = r_note;
        w_lat_oct_nxt   = r_lat_oct;
        w_from_hold_nxt = r_from_hold;
        w_wr_en         = 1'b0;
        w_wr_data       = {r_lat_oct, r_note, f_quant(r_dur)};

        // Simultaneous up and down cancel out.
        if (w_recording) begin
            if (oct_up && !oct_down && (r_octave < c_OCT_MAX))
                w_octave_nxt = r_octave + 1'b1;
            else if (oct_down && !oct_up && (r_octave > c_OCT_MIN))
                w_octave_nxt = r_octave - 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_cnt_nxt    = '0;
                    w_octave_nxt = c_OCT_RESET;
                    w_full_nxt   = 1'b0;
                    w_key_q_nxt  = c_NO_KEY;
                    w_dur_nxt    = '0;
                    w_state_nxt  = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!en) begin
                    w_from_hold_nxt = 1'b0;
                    w_state_nxt     = S_CLOSE;
                end else if (note_key != c_NO_KEY) begin
                    w_note_nxt    = NOTE_BITS'(note_key) + NOTE_BITS'(1);
                    w_lat_oct_nxt = r_octave;
                    w_dur_nxt     = '0;
                    w_key_q_nxt   = note_key;
                    w_state_nxt   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!en) begin
                    w_from_hold_nxt = 1'b1;
                    w_state_nxt     = S_CLOSE;
                end else if (note_key != r_key_q) begin
                    w_wr_en   = 1'b1;
                    w_cnt_nxt = w_cnt_inc;
                    w_dur_nxt = '0;
                    if (w_wr_fills) begin
                        w_full_nxt  = 1'b1;
                        w_track_nxt = c_FULL_CNT;
                        w_state_nxt = S_DONE;
                    end else if (note_key != c_NO_KEY) begin
                        w_note_nxt    = NOTE_BITS'(note_key) + NOTE_BITS'(1);
                        w_lat_oct_nxt = r_octave;
                        w_key_q_nxt   = note_key;
                    end else begin
                        w_key_q_nxt = c_NO_KEY;
                        w_state_nxt = S_GAP;
                    end
                end else if (beat_tick) begin
                    w_dur_nxt = w_dur_inc;
                end
            end
            S_GAP: begin
                if (!en) begin
                    w_from_hold_nxt = 1'b0;
                    w_state_nxt     = S_CLOSE;
                end else if (note_key != c_NO_KEY) begin
                    // A rest shorter than one time unit leaves no entry.
                    if (r_dur != 5'd0) begin
                        w_wr_en   = 1'b1;
                        w_wr_data = {r_lat_oct, NOTE_BITS'(0), f_quant(r_dur)};
                        w_cnt_nxt = w_cnt_inc;
                    end
                    w_dur_nxt = '0;
                    if ((r_dur != 5'd0) && w_wr_fills) begin
                        w_full_nxt  = 1'b1;
                        w_track_nxt = c_FULL_CNT;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_note_nxt    = NOTE_BITS'(note_key) + NOTE_BITS'(1);
                        w_lat_oct_nxt = r_octave;
                        w_key_q_nxt   = note_key;
                        w_state_nxt   = S_HOLD;
                    end
                end else if (beat_tick) begin
                    w_dur_nxt = w_dur_inc;
                end
            end
            S_CLOSE: begin
                if (r_from_hold) begin
                    w_wr_en     = 1'b1;
                    w_cnt_nxt   = w_cnt_inc;
                    w_track_nxt = w_cnt_inc;
                    if (w_wr_fills)
                        w_full_nxt = 1'b1;
                end else begin
                    w_track_nxt = r_cnt;
                end
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!en)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Track storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_cnt[DEPTH_BITS-1:0]] <= w_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rd_data <= '0;
        else
            r_rd_data <= r_mem[rd_addr];
    end

    assign {rd_octave, rd_note, rd_length} = r_rd_data;
    assign track     = r_track;
    assign recording = w_recording;
    assign full      = r_full;
    assign octave    = r_octave;

endmodule
`default_nettype wire

// File: tb/tb_record_mode.sv
`default_nettype none
// ============================================================================
// Module   : tb_record_mode
// Random takes against a segment-level model of the recorder.
// Revision : 1.0
// ============================================================================
module tb_record_mode;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       beat_tick = 1'b0;
    logic       oct_up = 1'b0;
    logic       oct_down = 1'b0;
    logic [2:0] note_key = 3'd7;
    logic [5:0] rd_addr = '0;
    logic [2:0] rd_octave;
    logic [3:0] rd_note;
    logic [2:0] rd_length;
    logic [6:0] track;
    logic       recording;
    logic       full;
    logic [2:0] octave;

    record_mode #(
        .DEPTH_BITS (6),
        .OCTAVE_BITS(3),
        .NOTE_BITS  (4),
        .LENGTH_BITS(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .beat_tick(beat_tick),
        .oct_up   (oct_up),
        .oct_down (oct_down),
        .note_key (note_key),
        .rd_addr  (rd_addr),
        .rd_octave(rd_octave),
        .rd_note  (rd_note),
        .rd_length(rd_length),
        .track    (track),
        .recording(recording),
        .full     (full),
        .octave   (octave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the expected take contents.
    logic [9:0] exp_mem [64];
    int         m_cnt;
    int         m_oct;
    bit         m_full;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Doubling thresholds 2,4,8,16 mark the length code boundaries.
    function automatic int quant(input int t);
        int code = 0;
        int lim  = 2;
        while (t >= lim && code < 4) begin
            code++;
            lim = lim * 2;
        end
        return code;
    endfunction

    task automatic push(input int oct, input int note, input int t);
        if (!m_full) begin
            exp_mem[m_cnt] = {3'(oct), 4'(note), 3'(quant(t))};
            m_cnt++;
            if (m_cnt == 64) m_full = 1'b1;
        end
    endtask

    task automatic drive(input int k, input bit tk, input bit up, input bit dn);
        note_key  = 3'(k);
        beat_tick = tk;
        oct_up    = up;
        oct_down  = dn;
        step();
        beat_tick = 1'b0;
        oct_up    = 1'b0;
        oct_down  = 1'b0;
    endtask

    task automatic run_take(input int nseg, input bit alt);
        int  prev_key;
        int  prev_t;
        int  cur_oct;
        int  k;
        int  t;
        bit  up;
        bit  dn;
        bit  was_full;
        prev_key = 7;
        prev_t   = 0;
        cur_oct  = 4;
        m_cnt    = 0;
        m_full   = 1'b0;
        m_oct    = 4;

        en = 1'b1;
        note_key = 3'd7;
        step();
        check("recording_start", recording, 1);
        check("octave_start", octave, 4);
        repeat ($urandom % 3) drive(7, $urandom_range(0, 1), 0, 0);

        for (int s = 0; s < nseg; s++) begin
            if (alt) begin
                k  = s % 2;
                t  = 1;
                up = 1'b0;
                dn = 1'b0;
            end else begin
                do k = $urandom % 8; while (k == prev_key);
                t  = ($urandom % 5 == 0) ? $urandom % 24 : $urandom % 6;
                up = ($urandom % 4 == 0);
                dn = ($urandom % 4 == 0);
            end
            was_full = m_full;
            if (s > 0) begin
                if (prev_key != 7) push(cur_oct, prev_key + 1, prev_t);
                else if (prev_t >= 1) push(cur_oct, 0, prev_t);
            end
            if (!was_full) begin
                if (k != 7) cur_oct = m_oct;
                if (up && !dn && m_oct < 7) m_oct++;
                else if (dn && !up && m_oct > 1) m_oct--;
            end
            // A tick on the key-change cycle must not count toward either entry.
            drive(k, alt ? 1'b0 : 1'($urandom % 2), up, dn);
            for (int i = 0; i < t; i++) begin
                repeat ($urandom % 2) drive(k, 0, 0, 0);
                drive(k, 1, 0, 0);
            end
            prev_key = k;
            prev_t   = t;
        end
        if (prev_key != 7) push(cur_oct, prev_key + 1, prev_t);

        en = 1'b0;
        step();
        step();
        check("track", track, m_cnt);
        check("full", full, m_full);
        check("octave_end", octave, m_oct);
        check("recording_end", recording, 0);
        step();
        for (int i = 0; i < m_cnt; i++) begin
            rd_addr = 6'(i);
            step();
            check($sformatf("entry%0d", i), {rd_octave, rd_note, rd_length}, exp_mem[i]);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_track", track, 0);
        check("rst_full", full, 0);
        check("rst_octave", octave, 4);
        check("rst_recording", recording, 0);
        check("rst_rd", {rd_octave, rd_note, rd_length}, 0);
        rst_n = 1'b1;
        step();
        check("idle_recording", recording, 0);

        for (int n = 0; n < 25; n++)
            run_take(1 + $urandom % 12, 1'b0);

        // 66 back-to-back one-tick notes: the take fills at 64 entries.
        run_take(66, 1'b1);
        check("full_track", track, 64);
        check("full_flag", full, 1);

        // Asynchronous reset while holding a note.
        en = 1'b1;
        step();
        drive(3, 0, 1, 0);
        drive(3, 1, 0, 0);
        check("hold_recording", recording, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_recording", recording, 0);
        check("arst_track", track, 0);
        check("arst_octave", octave, 4);
        check("arst_full", full, 0);
        check("arst_rd", {rd_octave, rd_note, rd_length}, 0);
        en = 1'b0;
        note_key = 3'd7;
        step();
        rst_n = 1'b1;
        rd_addr = 6'd0;
        step();
        check("arst_mem0", {rd_octave, rd_note, rd_length}, exp_mem[0]);
        check("arst_track_hold", track, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
